sdram_cmd_responder: RTL and testbench
======================================

Name: sdram_cmd_responder

Overview:
- Synthesizable SDRAM device-side responder: the other end of the SDRAM command/data bus that our controller drives.
- Decodes CS/RAS/CAS/WE commands, tracks per-bank open rows, honours the mode register (CAS latency, burst length), stores write bursts and returns read bursts on the bidirectional dq bus.
- Used in simulation and loopback FPGA builds so the controller/FIFO path is exercised without external memory; also reports protocol violations.

Parameters:
- MEM_AW, 12, address bits of internal storage (2^MEM_AW x 16-bit words); the word index is the low MEM_AW bits of {ba, row, col}.
- INIT_MODE, 13'h037, mode-register value applied by reset (CL=3, sequential, full page).

Ports:
- clk  input  1  system clock (same clock as the SDRAM clock output)
- rst_n  input  1  asynchronous active-low reset
- cke  input  1  clock enable; low = clock suspend
- sdram_cs_n  input  1  chip select, active low
- sdram_ras_n  input  1  row strobe
- sdram_cas_n  input  1  column strobe
- sdram_we_n  input  1  write enable
- sdram_ba  input  2  bank address
- sdram_addr  input  13  row / column / mode address; A10 = precharge-all
- sdram_dq  inout  16  data bus; driven only while read data is valid
- sdram_dqm  input  2  write byte mask; [1] masks dq[15:8], [0] masks dq[7:0]
- init_done  output  1  high once a LOAD MODE command has been accepted
- cmd_err  output  1  sticky protocol-violation flag
- ref_cnt  output  16  count of AUTO REFRESH commands, wraps at 16'hFFFF
- burst_busy  output  1  high while a read or write burst is in progress

Behaviour:
- Reset (async assert, sync release):
  - All banks closed; mode = INIT_MODE.
  - init_done=0, cmd_err=0, ref_cnt=0, burst_busy=0, dq hi-Z.
  - Memory contents are not cleared.
- Command sampling:
  - Commands are sampled on the rising clk edge when cke=1. With cke=0, no command is decoded, burst counters and the read pipeline hold, and dq keeps its current drive state.
  - cs_n=1 or {ras,cas,we}=111 is a NOP.
- Command decode, {ras_n,cas_n,we_n}:
  - 011 ACTIVE: opens row addr in bank ba. Bank already open -> cmd_err.
  - 010 PRECHARGE: closes bank ba, or all banks if addr[10]=1. Stops any burst in an affected bank.
  - 001 AUTO REFRESH: ref_cnt+1. Any bank open -> cmd_err.
  - 000 LOAD MODE: mode<=addr; init_done<=1. Any bank open or burst active -> cmd_err.
  - 101 READ / 100 WRITE: column = addr[8:0] in bank ba. The bank must be open and init_done must be 1, else cmd_err and the command is ignored.
  - 110 BURST TERMINATE: ends the current burst.
- Mode register fields:
  - CL = mode[6:4]; only 2 and 3 are legal, other values set cmd_err and CL=3 is used.
  - BL = mode[2:0]: 000=1, 001=2, 010=4, 011=8, 111=full page (512). Other values set cmd_err and BL=1 is used.
  - mode[3] is ignored (sequential only). mode[9]=1 makes writes single-location.
- Addressing:
  - Burst column increments sequentially and wraps within the BL-aligned block (full page: modulo 512).
  - A full-page burst runs until terminated by BURST TERMINATE, PRECHARGE, or a new READ/WRITE.
- Write burst:
  - Word 0 is captured on the WRITE command edge; word k on the k-th following enabled edge.
  - A dqm bit of 1 leaves the corresponding byte unchanged.
- Read burst:
  - Word 0 is driven on dq starting at the edge CL-1 after the READ edge, so the controller samples it at edge CL. Each following word is driven one enabled cycle later.
  - Implemented as a CL-1 stage pipeline of {valid, data}. Termination stops new issues; words already in the pipeline still drive. dq returns to hi-Z the cycle after the last valid word.
  - Read dqm is ignored.
- Burst interruption:
  - A new READ/WRITE during a burst terminates the old burst on that edge and starts the new one.
  - A WRITE issued while read words are still in the pipeline causes bus contention: set cmd_err, flush the pipeline, and write wins.
- Status and counters:
  - burst_busy = a burst counter is active OR any read pipeline stage is valid.
  - A simultaneous PRECHARGE to a bank and a READ to that bank cannot occur (one command per edge).
  - ref_cnt wraps 16'hFFFF -> 0.
- Reset mid-burst: burst aborts immediately; dq goes hi-Z asynchronously.

Test Plan:
- Reset, then LOAD MODE 13'h032 (CL=3, BL=4), ACTIVE ba=1 row=5, WRITE col=0 with data 1111,2222,3333,4444, then READ col=0 -> words appear at READ+3..+6 in order; dq hi-Z before and after; cmd_err=0.
- CL=2, full page: WRITE col=510 with 4 words A,B,C,D then BURST TERMINATE; READ col=510 and terminate after 4 -> data A,B,C,D from columns 510,511,0,1 (wrap), starting at READ+2.
- WRITE 16'hABCD, then WRITE same column 16'h1234 with dqm=2'b10, then READ -> 16'hAB34.
- READ to a closed bank, ACTIVE to an open bank, and REFRESH with a bank open -> cmd_err rises on the first violation and stays 1; a legal REFRESH later increments ref_cnt.
- READ BL=8 with cke held low for 3 cycles mid-burst -> the word on dq holds for 3 cycles and the burst resumes with no words lost or duplicated.
- Assert rst_n low during a read burst -> dq hi-Z immediately, burst_busy=0, init_done=0; a READ after reset, before LOAD MODE, sets cmd_err.

Source files
------------

// File: rtl/sdram_cmd_responder_if.sv
// SDRAM command/control bundle between a controller and a device-side responder.
// The bidirectional data bus stays a plain inout on the responder so that
// tristate resolution happens on an ordinary net.
//   cke                - clock enable, low = clock suspend
//   sdram_cs_n/ras_n/cas_n/we_n - command strobes, active low
//   sdram_ba           - bank address
//   sdram_addr         - row / column / mode address, A10 = precharge-all
//   sdram_dqm          - write byte mask, [1] -> dq[15:8], [0] -> dq[7:0]
interface sdram_cmd_responder_if;
    logic        cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_dqm;

    modport master (
        output cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr, sdram_dqm
    );

    modport slave (
        input cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input sdram_ba, sdram_addr, sdram_dqm
    );
endinterface

// File: rtl/sdram_cmd_responder.sv
// Device-side SDRAM model: decodes commands, tracks open rows per bank, honours
// the mode register (CAS latency 2/3, burst length 1/2/4/8/full page), stores
// write bursts and returns read bursts on dq. Protocol violations set a sticky
// error flag.
//   clk, rst_n  - clock, asynchronous active-low reset
//   bus         - command bundle (slave side)
//   sdram_dq    - data bus, driven only while a read word is valid
//   init_done   - a LOAD MODE has been accepted
//   cmd_err     - sticky protocol-violation flag
//   ref_cnt     - AUTO REFRESH count, wrapping
//   burst_busy  - burst counter active or read words still in flight
module sdram_cmd_responder #(
    parameter int unsigned MEM_AW    = 12,
    parameter logic [12:0] INIT_MODE = 13'h037
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdram_cmd_responder_if.slave  bus,
    inout  wire  [15:0]           sdram_dq,
    output logic                  init_done,
    output logic                  cmd_err,
    output logic [15:0]           ref_cnt,
    output logic                  burst_busy
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} bst_state_e;

    localparam logic [2:0] CmdActive    = 3'b011;
    localparam logic [2:0] CmdPrecharge = 3'b010;
    localparam logic [2:0] CmdRefresh   = 3'b001;
    localparam logic [2:0] CmdLoadMode  = 3'b000;
    localparam logic [2:0] CmdRead      = 3'b101;
    localparam logic [2:0] CmdWrite     = 3'b100;
    localparam logic [2:0] CmdBurstTerm = 3'b110;

    function automatic logic [MEM_AW-1:0] word_idx(logic [1:0] ba, logic [12:0] row,
                                                   logic [8:0] col);
        logic [23:0] full;
        full = {ba, row, col};
        return full[MEM_AW-1:0];
    endfunction

    // Sequential increment that wraps inside the mask-aligned block.
    function automatic logic [8:0] col_wrap(logic [8:0] col, logic [8:0] mask);
        return (col & ~mask) | ((col + 9'd1) & mask);
    endfunction

    function automatic logic mode_legal(logic [12:0] m);
        logic cl_ok;
        logic bl_ok;
        cl_ok = (m[6:4] == 3'd2) || (m[6:4] == 3'd3);
        bl_ok = (m[2:0] inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b111});
        return cl_ok && bl_ok;
    endfunction

    logic [15:0]      mem [2**MEM_AW];

    logic [3:0]       bank_open_q, bank_open_d;
    logic [3:0][12:0] row_q, row_d;
    logic [12:0]      mode_q, mode_d;
    logic             init_done_q, init_done_d;
    logic             cmd_err_q, cmd_err_d;
    logic [15:0]      ref_cnt_q, ref_cnt_d;
    bst_state_e       st_q, st_d;
    logic [1:0]       bst_bank_q, bst_bank_d;
    logic [12:0]      bst_row_q, bst_row_d;
    logic [8:0]       bst_col_q, bst_col_d;
    logic [8:0]       bst_mask_q, bst_mask_d;
    logic             bst_full_q, bst_full_d;
    logic [9:0]       bst_left_q, bst_left_d;
    // Stage 1 drives dq; with CL=2 reads issue straight into stage 1.
    logic [1:0]       pipe_vld_q, pipe_vld_d;
    logic [1:0][15:0] pipe_dat_q, pipe_dat_d;

    logic [2:0]        cmd;
    logic              cl3;
    logic [8:0]        bl_mask;
    logic              bl_full;
    logic              kill, start_rd, start_wr;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_widx;
    logic [MEM_AW-1:0] cur_idx;
    logic [15:0]       rd_word;
    logic              dq_oe;
    logic              unused_mode;

    assign cmd         = {bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
    assign cl3         = (mode_q[6:4] != 3'd2);
    assign cur_idx     = word_idx(bst_bank_q, bst_row_q, bst_col_q);
    assign rd_word     = mem[cur_idx];
    assign unused_mode = ^{mode_q[12:10], mode_q[8:7], mode_q[3]};

    always_comb begin
        bl_mask = 9'd0;
        bl_full = 1'b0;
        case (mode_q[2:0])
            3'b001:  bl_mask = 9'd1;
            3'b010:  bl_mask = 9'd3;
            3'b011:  bl_mask = 9'd7;
            3'b111: begin
                bl_mask = 9'd511;
                bl_full = 1'b1;
            end
            default: bl_mask = 9'd0;
        endcase
    end

    always_comb begin
        bank_open_d = bank_open_q;
        row_d       = row_q;
        mode_d      = mode_q;
        init_done_d = init_done_q;
        cmd_err_d   = cmd_err_q;
        ref_cnt_d   = ref_cnt_q;
        st_d        = st_q;
        bst_bank_d  = bst_bank_q;
        bst_row_d   = bst_row_q;
        bst_col_d   = bst_col_q;
        bst_mask_d  = bst_mask_q;
        bst_full_d  = bst_full_q;
        bst_left_d  = bst_left_q;
        pipe_vld_d  = pipe_vld_q;
        pipe_dat_d  = pipe_dat_q;
        mem_we      = 1'b0;
        mem_widx    = cur_idx;
        kill        = 1'b0;
        start_rd    = 1'b0;
        start_wr    = 1'b0;

        if (bus.cke && !bus.sdram_cs_n) begin
            case (cmd)
                CmdActive: begin
                    if (bank_open_q[bus.sdram_ba]) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        bank_open_d[bus.sdram_ba] = 1'b1;
                        row_d[bus.sdram_ba]       = bus.sdram_addr;
                    end
                end
                CmdPrecharge: begin
                    if (bus.sdram_addr[10]) begin
                        bank_open_d = '0;
                        kill        = 1'b1;
                    end else begin
                        bank_open_d[bus.sdram_ba] = 1'b0;
                        kill                      = (bst_bank_q == bus.sdram_ba);
                    end
                end
                CmdRefresh: begin
                    ref_cnt_d = ref_cnt_q + 16'd1;
                    if (|bank_open_q) cmd_err_d = 1'b1;
                end
                CmdLoadMode: begin
                    mode_d      = bus.sdram_addr;
                    init_done_d = 1'b1;
                    if ((|bank_open_q) || burst_busy || !mode_legal(bus.sdram_addr)) begin
                        cmd_err_d = 1'b1;
                    end
                end
                CmdRead, CmdWrite: begin
                    if (bank_open_q[bus.sdram_ba] && init_done_q) begin
                        kill     = 1'b1;
                        start_rd = (cmd == CmdRead);
                        start_wr = (cmd == CmdWrite);
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                CmdBurstTerm: kill = 1'b1;
                default: ;
            endcase
        end

        if (bus.cke) begin
            pipe_vld_d    = {pipe_vld_q[0], 1'b0};
            pipe_dat_d[1] = pipe_dat_q[0];

            if (kill) begin
                st_d = StIdle;
            end else if (st_q != StIdle) begin
                if (st_q == StRead) begin
                    if (cl3) begin
                        pipe_vld_d[0] = 1'b1;
                        pipe_dat_d[0] = rd_word;
                    end else begin
                        pipe_vld_d[1] = 1'b1;
                        pipe_dat_d[1] = rd_word;
                    end
                end else begin
                    mem_we = 1'b1;
                end
                bst_col_d = col_wrap(bst_col_q, bst_mask_q);
                if (!bst_full_q) begin
                    bst_left_d = bst_left_q - 10'd1;
                    if (bst_left_q == 10'd1) st_d = StIdle;
                end
            end

            if (start_rd || start_wr) begin
                bst_bank_d = bus.sdram_ba;
                bst_row_d  = row_q[bus.sdram_ba];
                bst_mask_d = bl_mask;
                bst_full_d = bl_full;
                if (start_rd) begin
                    st_d       = StRead;
                    bst_col_d  = bus.sdram_addr[8:0];
                    bst_left_d = {1'b0, bl_mask} + 10'd1;
                end else begin
                    // Word 0 lands on the command edge itself.
                    mem_we     = 1'b1;
                    mem_widx   = word_idx(bus.sdram_ba, row_q[bus.sdram_ba],
                                          bus.sdram_addr[8:0]);
                    bst_col_d  = col_wrap(bus.sdram_addr[8:0], bl_mask);
                    bst_left_d = {1'b0, bl_mask};
                    st_d       = (mode_q[9] || (bl_mask == 9'd0)) ? StIdle : StWrite;
                    // Read words still in flight would collide with write data.
                    if (|pipe_vld_q) begin
                        cmd_err_d  = 1'b1;
                        pipe_vld_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_open_q <= '0;
            row_q       <= '0;
            mode_q      <= INIT_MODE;
            init_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            ref_cnt_q   <= 16'd0;
            st_q        <= StIdle;
            bst_bank_q  <= 2'd0;
            bst_row_q   <= 13'd0;
            bst_col_q   <= 9'd0;
            bst_mask_q  <= 9'd0;
            bst_full_q  <= 1'b0;
            bst_left_q  <= 10'd0;
            pipe_vld_q  <= '0;
            pipe_dat_q  <= '0;
        end else begin
            bank_open_q <= bank_open_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            init_done_q <= init_done_d;
            cmd_err_q   <= cmd_err_d;
            ref_cnt_q   <= ref_cnt_d;
            st_q        <= st_d;
            bst_bank_q  <= bst_bank_d;
            bst_row_q   <= bst_row_d;
            bst_col_q   <= bst_col_d;
            bst_mask_q  <= bst_mask_d;
            bst_full_q  <= bst_full_d;
            bst_left_q  <= bst_left_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_dat_q  <= pipe_dat_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (!bus.sdram_dqm[0]) mem[mem_widx][7:0]  <= sdram_dq[7:0];
            if (!bus.sdram_dqm[1]) mem[mem_widx][15:8] <= sdram_dq[15:8];
        end
    end

    assign dq_oe      = pipe_vld_q[1];
    assign sdram_dq   = dq_oe ? pipe_dat_q[1] : 16'hzzzz;
    assign init_done  = init_done_q;
    assign cmd_err    = cmd_err_q;
    assign ref_cnt    = ref_cnt_q;
    assign burst_busy = (st_q != StIdle) || (|pipe_vld_q);

endmodule

// File: tb/tb_sdram_cmd_responder.sv
module tb_sdram_cmd_responder;

    localparam logic [2:0] CmdNop = 3'b111;
    localparam logic [2:0] CmdAct = 3'b011;
    localparam logic [2:0] CmdPre = 3'b010;
    localparam logic [2:0] CmdRef = 3'b001;
    localparam logic [2:0] CmdLmr = 3'b000;
    localparam logic [2:0] CmdRd  = 3'b101;
    localparam logic [2:0] CmdWr  = 3'b100;
    localparam logic [2:0] CmdBst = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_oe;
    logic [15:0] tb_dq;
    wire  [15:0] dq;
    logic        init_done, cmd_err, burst_busy;
    logic [15:0] ref_cnt;

    sdram_cmd_responder_if bus ();

    assign dq = tb_oe ? tb_dq : 16'hzzzz;

    sdram_cmd_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sdram_dq   (dq),
        .init_done  (init_done),
        .cmd_err    (cmd_err),
        .ref_cnt    (ref_cnt),
        .burst_busy (burst_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: memory image, open rows, decoded mode.
    logic [15:0] mdl [4096];
    int          tb_row [4];
    int          tb_cl;
    int          tb_bl;
    int          exp_ref;
    logic [15:0] wbuf [8];
    logic [1:0]  wmsk [8];

    function automatic int widx(int ba, int row, int col);
        return (ba * (1 << 22) + row * 512 + col) % 4096;
    endfunction

    function automatic int wcol(int col, int i, int bl);
        return (col / bl) * bl + (col % bl + i) % bl;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one command/data set for the next rising edge.
    task automatic tick(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                        input logic oe, input logic [15:0] d, input logic [1:0] m,
                        input logic ke);
        @(negedge clk);
        bus.cke         = ke;
        bus.sdram_cs_n  = 1'b0;
        bus.sdram_ras_n = c[2];
        bus.sdram_cas_n = c[1];
        bus.sdram_we_n  = c[0];
        bus.sdram_ba    = ba;
        bus.sdram_addr  = a;
        bus.sdram_dqm   = m;
        tb_oe           = oe;
        tb_dq           = d;
    endtask

    task automatic nop();
        tick(CmdNop, 2'd0, 13'd0, 1'b0, 16'd0, 2'd0, 1'b1);
    endtask

    task automatic load_mode(input logic [12:0] m);
        tick(CmdPre, 2'd0, 13'h400, 1'b0, 16'd0, 2'd0, 1'b1);
        tick(CmdLmr, 2'd0, m, 1'b0, 16'd0, 2'd0, 1'b1);
        tb_cl = int'(m[6:4]);
        tb_bl = (m[2:0] == 3'b111) ? 512 : (1 << m[2:0]);
    endtask

    task automatic open_row(input logic [1:0] ba, input int row);
        tick(CmdAct, ba, 13'(row), 1'b0, 16'd0, 2'd0, 1'b1);
        tb_row[ba] = row;
    endtask

    task automatic wr_burst(input logic [1:0] ba, input int col, input int n, input bit bst);
        int idx;
        for (int i = 0; i < n; i++) begin
            tick((i == 0) ? CmdWr : CmdNop, ba, 13'(col), 1'b1, wbuf[i], wmsk[i], 1'b1);
            idx = widx(ba, tb_row[ba], wcol(col, i, tb_bl));
            if (!wmsk[i][0]) mdl[idx][7:0]  = wbuf[i][7:0];
            if (!wmsk[i][1]) mdl[idx][15:8] = wbuf[i][15:8];
        end
        tick(bst ? CmdBst : CmdNop, 2'd0, 13'd0, 1'b0, 16'd0, 2'd0, 1'b1);
    endtask

    // m counts enabled edges after the READ edge; word j is on dq once
    // m == j + CL - 1 and stays until the next enabled edge.
    task automatic rd_check(input string tag, input logic [1:0] ba, input int col,
                            input int n, input bit bst, input int stall_at);
        int m;
        int j;
        int k;
        logic ke;
        tick(CmdRd, ba, 13'(col), 1'b0, 16'd0, 2'd0, 1'b1);
        m = 0;
        k = 0;
        while ((m - tb_cl + 1 <= n) && (k < 200)) begin
            k++;
            ke = !(stall_at > 0 && k >= stall_at && k < stall_at + 3);
            tick((bst && ke && m == n) ? CmdBst : CmdNop, 2'd0, 13'd0, 1'b0, 16'd0,
                 2'd0, ke);
            j = m - tb_cl + 1;
            if (k == 1) chk({tag, " busy"}, 32'(burst_busy), 32'd1);
            if (j >= 0 && j < n) begin
                chk({tag, " oe"}, 32'(dut.dq_oe), 32'd1);
                chk({tag, " data"}, 32'(dq), 32'(mdl[widx(ba, tb_row[ba], wcol(col, j, tb_bl))]));
            end else begin
                chk({tag, " hiz"}, 32'(dut.dq_oe), 32'd0);
                if (j == n) chk({tag, " idle"}, 32'(burst_busy), 32'd0);
            end
            if (ke) m++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $error("FAIL %s timeout observed=%0d expected<200", tag, k);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int col;
        logic [1:0] rba;

        rst_n           = 1'b0;
        bus.cke         = 1'b1;
        bus.sdram_cs_n  = 1'b1;
        bus.sdram_ras_n = 1'b1;
        bus.sdram_cas_n = 1'b1;
        bus.sdram_we_n  = 1'b1;
        bus.sdram_ba    = 2'd0;
        bus.sdram_addr  = 13'd0;
        bus.sdram_dqm   = 2'd0;
        tb_oe           = 1'b0;
        tb_dq           = 16'd0;
        exp_ref         = 0;
        for (int i = 0; i < 8; i++) wmsk[i] = 2'b00;

        repeat (3) @(negedge clk);
        chk("rst init_done", 32'(init_done), 32'd0);
        chk("rst cmd_err", 32'(cmd_err), 32'd0);
        chk("rst ref_cnt", 32'(ref_cnt), 32'd0);
        chk("rst busy", 32'(burst_busy), 32'd0);
        chk("rst hiz", 32'(dut.dq_oe), 32'd0);
        rst_n = 1'b1;

        // CL=3, BL=4 write then read back.
        load_mode(13'h032);
        open_row(2'd1, 5);
        nop();
        chk("lmr init_done", 32'(init_done), 32'd1);
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        wr_burst(2'd1, 0, 4, 1'b0);
        rd_check("bl4", 2'd1, 0, 4, 1'b0, 0);
        chk("bl4 err", 32'(cmd_err), 32'd0);

        // CL=2 full page with column wrap, both bursts terminated.
        load_mode(13'h027);
        open_row(2'd1, 5);
        wbuf[0] = 16'hA0A0; wbuf[1] = 16'hB1B1; wbuf[2] = 16'hC2C2; wbuf[3] = 16'hD3D3;
        wr_burst(2'd1, 510, 4, 1'b1);
        rd_check("fpage", 2'd1, 510, 4, 1'b1, 0);
        chk("fpage wrap", 32'(mdl[widx(1, 5, 0)]), 32'h0000C2C2);
        chk("fpage err", 32'(cmd_err), 32'd0);

        // Byte masking on a single-word burst.
        load_mode(13'h020);
        open_row(2'd1, 5);
        wbuf[0] = 16'hABCD;
        wr_burst(2'd1, 7, 1, 1'b0);
        wbuf[0] = 16'h1234; wmsk[0] = 2'b10;
        wr_burst(2'd1, 7, 1, 1'b0);
        wmsk[0] = 2'b00;
        chk("dqm model", 32'(mdl[widx(1, 5, 7)]), 32'h0000AB34);
        rd_check("dqm", 2'd1, 7, 1, 1'b0, 0);

        // Randomised BL=8 bursts at random columns with random masks.
        load_mode(13'h033);
        rba = 2'($urandom_range(0, 3));
        open_row(rba, int'($urandom_range(0, 8191)));
        col = 0;
        for (int it = 0; it < 4; it++) begin
            col = int'($urandom_range(0, 511));
            for (int i = 0; i < 8; i++) begin
                wbuf[i] = 16'($urandom);
                wmsk[i] = 2'b00;
            end
            wr_burst(rba, col, 8, 1'b0);
            for (int i = 0; i < 8; i++) begin
                wbuf[i] = 16'($urandom);
                wmsk[i] = 2'($urandom_range(0, 3));
            end
            wr_burst(rba, col, 8, 1'b0);
            rd_check("rand", rba, col, 8, 1'b0, 0);
        end
        for (int i = 0; i < 8; i++) wmsk[i] = 2'b00;

        // Clock suspend mid-burst.
        rd_check("stall", rba, col, 8, 1'b0, 5);
        chk("stall err", 32'(cmd_err), 32'd0);

        // Protocol violations and refresh counting.
        tick(CmdPre, 2'd0, 13'h400, 1'b0, 16'd0, 2'd0, 1'b1);
        tick(CmdRd, 2'd2, 13'd0, 1'b0, 16'd0, 2'd0, 1'b1);
        nop();
        chk("err closed read", 32'(cmd_err), 32'd1);
        open_row(2'd0, 1);
        open_row(2'd0, 1);
        nop();
        chk("err double act", 32'(cmd_err), 32'd1);
        tick(CmdRef, 2'd0, 13'd0, 1'b0, 16'd0, 2'd0, 1'b1);
        exp_ref++;
        nop();
        chk("ref open", 32'(ref_cnt), 32'(exp_ref));
        tick(CmdPre, 2'd0, 13'h400, 1'b0, 16'd0, 2'd0, 1'b1);
        tick(CmdRef, 2'd0, 13'd0, 1'b0, 16'd0, 2'd0, 1'b1);
        exp_ref++;
        nop();
        chk("ref legal", 32'(ref_cnt), 32'(exp_ref));
        chk("err sticky", 32'(cmd_err), 32'd1);

        // Reset during a read burst.
        load_mode(13'h032);
        open_row(2'd1, 5);
        tick(CmdRd, 2'd1, 13'd0, 1'b0, 16'd0, 2'd0, 1'b1);
        repeat (4) nop();
        chk("pre-rst oe", 32'(dut.dq_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-rst hiz", 32'(dut.dq_oe), 32'd0);
        chk("mid-rst busy", 32'(burst_busy), 32'd0);
        chk("mid-rst init", 32'(init_done), 32'd0);
        chk("mid-rst err", 32'(cmd_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        open_row(2'd0, 2);
        nop();
        chk("post-rst act", 32'(cmd_err), 32'd0);
        tick(CmdRd, 2'd0, 13'd0, 1'b0, 16'd0, 2'd0, 1'b1);
        nop();
        chk("read before lmr", 32'(cmd_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
